// File: rtl/mem_port_arbiter.sv
// Serialises inst/data SRAM requests onto one req/gnt/rvalid memory port; data goes first.
// Min 3 stall cycles per request (5 for both); holds mem_req and its fields until gnt, waits unbounded for rvalid.
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int WE_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inst_sram_en,
  input  logic [WE_W-1:0]   inst_sram_we,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic [DATA_W-1:0] inst_sram_rdata,
  input  logic              data_sram_en,
  input  logic [WE_W-1:0]   data_sram_we,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              stallreq,
  output logic              mem_req,
  output logic [WE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [63:0]       stall_cycles
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] D_REQ  = 3'd1;
  localparam logic [2:0] D_WAIT = 3'd2;
  localparam logic [2:0] I_REQ  = 3'd3;
  localparam logic [2:0] I_WAIT = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0] state;
  logic [2:0] next_state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (data_sram_en)      next_state = D_REQ;
        else if (inst_sram_en) next_state = I_REQ;
      end
      D_REQ:  if (mem_gnt) next_state = D_WAIT;
      D_WAIT: if (mem_rvalid) next_state = inst_sram_en ? I_REQ : DONE;
      I_REQ:  if (mem_gnt) next_state = I_WAIT;
      I_WAIT: if (mem_rvalid) next_state = DONE;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields pass straight through; the pipeline holds them stable while stalled.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == D_REQ) begin
      mem_req   = 1'b1;
      mem_we    = data_sram_we;
      mem_addr  = data_sram_addr;
      mem_wdata = data_sram_wdata;
    end else if (state == I_REQ) begin
      mem_req   = 1'b1;
      mem_we    = inst_sram_we;
      mem_addr  = inst_sram_addr;
      mem_wdata = inst_sram_wdata;
    end
  end

  always_comb begin
    stallreq = 1'b0;
    case (state)
      IDLE:    stallreq = inst_sram_en | data_sram_en;
      DONE:    stallreq = 1'b0;
      default: stallreq = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      inst_sram_rdata <= '0;
      data_sram_rdata <= '0;
      stall_cycles    <= '0;
    end else begin
      state <= next_state;
      if (stallreq) stall_cycles <= stall_cycles + 64'd1;
      // Write acks complete the transaction but never disturb held read data.
      if (state == D_WAIT && mem_rvalid && data_sram_we == '0)
        data_sram_rdata <= mem_rdata;
      if (state == I_WAIT && mem_rvalid && inst_sram_we == '0)
        inst_sram_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge, outputs are checked 1ns later.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        inst_sram_en;
  logic [7:0]  inst_sram_we;
  logic [63:0] inst_sram_addr;
  logic [63:0] inst_sram_wdata;
  logic [63:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [7:0]  data_sram_we;
  logic [63:0] data_sram_addr;
  logic [63:0] data_sram_wdata;
  logic [63:0] data_sram_rdata;
  logic        stallreq;
  logic        mem_req;
  logic [7:0]  mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic [63:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stallreq        (stallreq),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_gnt         (mem_gnt),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .stall_cycles    (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    inst_sram_en = 1'b0; inst_sram_we = '0; inst_sram_addr = '0; inst_sram_wdata = '0;
    data_sram_en = 1'b0; data_sram_we = '0; data_sram_addr = '0; data_sram_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    tick(); tick(); settle();
    check("rst_stallreq", 64'(stallreq), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_inst_rdata", inst_sram_rdata, 64'd0);
    check("rst_data_rdata", data_sram_rdata, 64'd0);
    check("rst_stall_cycles", stall_cycles, 64'd0);
    reset = 1'b0;

    // Fetch only
    tick();
    inst_sram_en = 1'b1; inst_sram_addr = 64'h8000_0000; settle();
    check("f_idle_stall", 64'(stallreq), 64'd1);
    check("f_idle_req", 64'(mem_req), 64'd0);
    tick();
    mem_gnt = 1'b1; settle();
    check("f_req", 64'(mem_req), 64'd1);
    check("f_addr", mem_addr, 64'h8000_0000);
    check("f_req_stall", 64'(stallreq), 64'd1);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0000_0013_0000_0093; settle();
    check("f_wait_req", 64'(mem_req), 64'd0);
    check("f_wait_stall", 64'(stallreq), 64'd1);
    tick();
    mem_rvalid = 1'b0; settle();
    check("f_done_stall", 64'(stallreq), 64'd0);
    check("f_done_req", 64'(mem_req), 64'd0);
    check("f_inst_rdata", inst_sram_rdata, 64'h0000_0013_0000_0093);
    check("f_stall_cycles", stall_cycles, 64'd3);
    inst_sram_en = 1'b0;

    // Simultaneous load and fetch: data must reach the port first
    tick();
    data_sram_en = 1'b1; data_sram_addr = 64'h8000_1000;
    inst_sram_en = 1'b1; inst_sram_addr = 64'h8000_0004; settle();
    check("lf_idle_stall", 64'(stallreq), 64'd1);
    tick();
    mem_gnt = 1'b1; settle();
    check("lf_first_req", 64'(mem_req), 64'd1);
    check("lf_first_addr", mem_addr, 64'h8000_1000);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_DEAD_BEEF; settle();
    check("lf_dwait_req", 64'(mem_req), 64'd0);
    tick();
    mem_rvalid = 1'b0; mem_gnt = 1'b1; settle();
    check("lf_second_req", 64'(mem_req), 64'd1);
    check("lf_second_addr", mem_addr, 64'h8000_0004);
    check("lf_data_rdata", data_sram_rdata, 64'h0000_0000_DEAD_BEEF);
    check("lf_istall", 64'(stallreq), 64'd1);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h13; settle();
    check("lf_iwait_stall", 64'(stallreq), 64'd1);
    tick();
    mem_rvalid = 1'b0; settle();
    check("lf_done_stall", 64'(stallreq), 64'd0);
    check("lf_inst_rdata", inst_sram_rdata, 64'h13);
    check("lf_data_hold", data_sram_rdata, 64'h0000_0000_DEAD_BEEF);
    check("lf_stall_cycles", stall_cycles, 64'd8);
    data_sram_en = 1'b0; inst_sram_en = 1'b0;

    // Load 0xAB to set up the store test
    tick();
    data_sram_en = 1'b1; data_sram_addr = 64'h8000_1008;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hAB;
    tick();
    mem_rvalid = 1'b0; settle();
    check("ld_data_rdata", data_sram_rdata, 64'hAB);
    check("ld_stall_cycles", stall_cycles, 64'd11);
    data_sram_en = 1'b0;

    // Store with fetch
    tick();
    data_sram_en = 1'b1; data_sram_we = 8'hFF; data_sram_addr = 64'h8000_2000;
    data_sram_wdata = 64'h1122_3344_5566_7788;
    inst_sram_en = 1'b1; inst_sram_addr = 64'h8000_0008;
    tick();
    mem_gnt = 1'b1; settle();
    check("st_req", 64'(mem_req), 64'd1);
    check("st_we", 64'(mem_we), 64'hFF);
    check("st_addr", mem_addr, 64'h8000_2000);
    check("st_wdata", mem_wdata, 64'h1122_3344_5566_7788);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h9999;
    tick();
    mem_rvalid = 1'b0; mem_gnt = 1'b1; settle();
    check("st_fetch_addr", mem_addr, 64'h8000_0008);
    check("st_fetch_we", 64'(mem_we), 64'd0);
    check("st_rdata_hold", data_sram_rdata, 64'hAB);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h77;
    tick();
    mem_rvalid = 1'b0; settle();
    check("st_done_stall", 64'(stallreq), 64'd0);
    check("st_inst_rdata", inst_sram_rdata, 64'h77);
    check("st_data_rdata", data_sram_rdata, 64'hAB);
    check("st_stall_cycles", stall_cycles, 64'd16);
    data_sram_en = 1'b0; data_sram_we = '0; data_sram_wdata = '0; inst_sram_en = 1'b0;

    // Back-pressure: gnt low for 4 cycles with a stray rvalid
    tick();
    data_sram_en = 1'b1; data_sram_addr = 64'h8000_3000;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_rvalid = (i == 1); mem_rdata = 64'h66; settle();
      check("bp_req", 64'(mem_req), 64'd1);
      check("bp_addr", mem_addr, 64'h8000_3000);
      check("bp_stall", 64'(stallreq), 64'd1);
    end
    check("bp_rdata_hold", data_sram_rdata, 64'hAB);
    tick();
    mem_rvalid = 1'b0; mem_gnt = 1'b1; settle();
    check("bp_gnt_req", 64'(mem_req), 64'd1);
    tick();
    mem_gnt = 1'b0; settle();
    check("bp_wait_req", 64'(mem_req), 64'd0);
    check("bp_wait_stall", 64'(stallreq), 64'd1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'hC0FFEE; settle();
    check("bp_wait2_stall", 64'(stallreq), 64'd1);
    tick();
    mem_rvalid = 1'b0; settle();
    check("bp_done_stall", 64'(stallreq), 64'd0);
    check("bp_data_rdata", data_sram_rdata, 64'hC0FFEE);
    check("bp_stall_cycles", stall_cycles, 64'd24);
    data_sram_en = 1'b0;

    // Idle
    for (int i = 0; i < 10; i++) begin
      tick(); settle();
      check("idle_stall", 64'(stallreq), 64'd0);
      check("idle_req", 64'(mem_req), 64'd0);
    end
    check("idle_stall_cycles", stall_cycles, 64'd24);

    // Reset while in I_WAIT, then a late rvalid
    tick();
    inst_sram_en = 1'b1; inst_sram_addr = 64'h8000_000C;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; inst_sram_en = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h55; settle();
    check("rw_req", 64'(mem_req), 64'd0);
    check("rw_stall", 64'(stallreq), 64'd0);
    check("rw_inst_rdata", inst_sram_rdata, 64'd0);
    check("rw_stall_cycles", stall_cycles, 64'd0);
    tick();
    mem_rvalid = 1'b0; settle();
    check("rw_late_rdata", inst_sram_rdata, 64'd0);
    check("rw_data_rdata", data_sram_rdata, 64'd0);
    check("rw_idle_req", 64'(mem_req), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
